// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline registers.
//   occ_e          occupancy encoding of a stage register (0, 1 or 2 entries)
//   NOP_CTRL       all-zero control bundle (bubble); slice to the stage width
//   *_CTRL_W/_W    control/data bundle widths for each pipeline boundary
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HEAD  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int NOP_CTRL_MAX_W = 64;
    localparam logic [NOP_CTRL_MAX_W-1:0] NOP_CTRL = '0;

    localparam int IF_ID_CTRL_W  = 4;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 16;
    localparam int ID_EX_DATA_W  = 128;
    localparam int EX_MEM_CTRL_W = 8;
    localparam int EX_MEM_DATA_W = 96;
    localparam int MEM_WB_CTRL_W = 4;
    localparam int MEM_WB_DATA_W = 69;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: width-parametrised saturating up-counter.
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset, clears the count
//   clear    synchronous clear
//   inc      increment request for this cycle
//   count    current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, flush-to-bubble and a stall-cycle counter.
//   clock, reset_n         clock and synchronous active-low reset
//   flush                  drop held and incoming entries this cycle
//   in_valid/in_ready      upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready    downstream handshake, out_ctrl/out_data head (0 when empty)
//   occupancy              entries held (0..2, max 1 when SKID=0)
//   stall_count            saturating count of out_valid && !out_ready cycles
//
// state      | meaning
// -----------+----------------------------------------------
// OCC_EMPTY  | nothing held, out_valid=0
// OCC_HEAD   | head slot holds the entry presented downstream
// OCC_FULL   | head and skid slot both held (SKID=1 only), in_ready=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        LD_HOLD,
        LD_IN,
        LD_SKID,
        LD_CLR
    } head_ld_e;

    occ_e              state_q;
    occ_e              state_d;
    head_ld_e          head_ld;
    logic              skid_ld;
    logic              accept;
    logic              consume;
    logic [CTRL_W-1:0] head_ctrl_q;
    logic [DATA_W-1:0] head_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and slot load controls; flush overrides everything
    always_comb begin
        state_d = state_q;
        head_ld = LD_HOLD;
        skid_ld = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
            head_ld = LD_CLR;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d = OCC_HEAD;
                        head_ld = LD_IN;
                    end
                end
                OCC_HEAD: begin
                    if (accept && consume) begin
                        head_ld = LD_IN;
                    end else if (accept) begin
                        // only reachable with SKID=1: SKID=0 accepts in HEAD only alongside a consume
                        state_d = OCC_FULL;
                        skid_ld = 1'b1;
                    end else if (consume) begin
                        state_d = OCC_EMPTY;
                        head_ld = LD_CLR;
                    end
                end
                OCC_FULL: begin
                    if (consume) begin
                        state_d = OCC_HEAD;
                        head_ld = LD_SKID;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                    head_ld = LD_CLR;
                end
            endcase
        end
    end

    // outputs
    always_comb begin
        out_valid = (state_q != OCC_EMPTY);
        occupancy = state_q;
        out_ctrl  = out_valid ? head_ctrl_q : NOP_CTRL[CTRL_W-1:0];
        out_data  = out_valid ? head_data_q : '0;
    end

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;

            // registered ready: decided from the next state, so no out_ready path
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != OCC_FULL);
                end
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_ctrl_q <= '0;
            head_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            case (head_ld)
                LD_IN: begin
                    head_ctrl_q <= in_ctrl;
                    head_data_q <= in_data;
                end
                LD_SKID: begin
                    head_ctrl_q <= skid_ctrl_q;
                    head_data_q <= skid_data_q;
                end
                LD_CLR: begin
                    head_ctrl_q <= '0;
                    head_data_q <= '0;
                end
                default: begin
                end
            endcase
            if (skid_ld) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (1'b0),
        .inc     (out_valid && !out_ready),
        .count   (stall_count)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg.
//   u_dut_a  SKID=1, CNT_W=4   (streaming, backpressure, flush, saturation)
//   u_dut_b  SKID=0, CNT_W=16  (combinational ready)
module tb_pipe_stage_reg;

    logic         clock;
    logic         reset_n;

    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0]  a_in_ctrl, a_out_ctrl;
    logic [127:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic [3:0]   a_stall;

    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [15:0]  b_in_ctrl, b_out_ctrl;
    logic [127:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
    logic [15:0]  b_stall;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(1), .CNT_W(4)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ), .stall_count(a_stall)
    );

    pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(0), .CNT_W(16)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ), .stall_count(b_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic a_offer(input logic v, input logic [15:0] c, input logic [127:0] d);
        a_in_valid = v;
        a_in_ctrl  = c;
        a_in_data  = d;
    endtask

    initial begin
        reset_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;

        // 1. reset, streaming, mid-stream reset
        step();
        step();
        reset_n = 1'b1;
        chk("rst_occ",      128'(a_occ), 128'd0);
        chk("rst_valid",    128'(a_out_valid), 128'd0);
        chk("rst_ctrl",     128'(a_out_ctrl), 128'd0);
        chk("rst_data",     a_out_data, 128'd0);
        chk("rst_stall",    128'(a_stall), 128'd0);
        chk("rst_in_ready", 128'(a_in_ready), 128'd1);

        a_offer(1'b1, 16'h00A5, 128'h1234);
        a_out_ready = 1'b1;
        step();
        a_offer(1'b0, 16'h0, 128'h0);
        chk("first_valid", 128'(a_out_valid), 128'd1);
        chk("first_ctrl",  128'(a_out_ctrl), 128'h00A5);
        chk("first_data",  a_out_data, 128'h1234);
        chk("first_occ",   128'(a_occ), 128'd1);

        for (int i = 0; i < 8; i++) begin
            a_offer(1'b1, 16'(i + 1), 128'(256 + i));
            step();
            chk("stream_ctrl", 128'(a_out_ctrl), 128'(i + 1));
            chk("stream_data", a_out_data, 128'(256 + i));
        end
        chk("stream_occ", 128'(a_occ), 128'd1);

        a_offer(1'b1, 16'h0077, 128'h7777);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        a_offer(1'b0, 16'h0, 128'h0);
        a_out_ready = 1'b0;
        chk("midrst_occ",   128'(a_occ), 128'd0);
        chk("midrst_valid", 128'(a_out_valid), 128'd0);
        chk("midrst_ctrl",  128'(a_out_ctrl), 128'd0);
        chk("midrst_stall", 128'(a_stall), 128'd0);

        // 2. skid backpressure
        a_offer(1'b1, 16'h000A, 128'hAAAA);
        step();
        chk("bp_a_occ",      128'(a_occ), 128'd1);
        chk("bp_a_in_ready", 128'(a_in_ready), 128'd1);
        a_offer(1'b1, 16'h000B, 128'hBBBB);
        step();
        chk("bp_b_occ",      128'(a_occ), 128'd2);
        chk("bp_b_in_ready", 128'(a_in_ready), 128'd0);
        chk("bp_b_head",     a_out_data, 128'hAAAA);
        chk("bp_b_stall",    128'(a_stall), 128'd1);
        a_offer(1'b1, 16'h000C, 128'hCCCC);
        step();
        chk("bp_c_occ",   128'(a_occ), 128'd2);
        chk("bp_c_head",  128'(a_out_ctrl), 128'h000A);
        chk("bp_c_stall", 128'(a_stall), 128'd2);
        a_offer(1'b0, 16'h0, 128'h0);
        a_out_ready = 1'b1;
        #1;
        chk("bp_ready_reg", 128'(a_in_ready), 128'd0);
        chk("drain_a",      a_out_data, 128'hAAAA);
        step();
        chk("drain_b",     a_out_data, 128'hBBBB);
        chk("drain_b_occ", 128'(a_occ), 128'd1);
        step();
        chk("drain_occ",   128'(a_occ), 128'd0);
        chk("drain_valid", 128'(a_out_valid), 128'd0);
        chk("drain_data",  a_out_data, 128'd0);
        chk("drain_stall", 128'(a_stall), 128'd2);
        a_out_ready = 1'b0;

        // 3. flush with a concurrent offer while FULL
        a_offer(1'b1, 16'h000E, 128'hEEEE);
        step();
        a_offer(1'b1, 16'h000F, 128'hFFFF);
        step();
        chk("fl_full_occ", 128'(a_occ), 128'd2);
        a_flush = 1'b1;
        a_offer(1'b1, 16'h000D, 128'hDDDD);
        step();
        a_flush = 1'b0;
        a_offer(1'b0, 16'h0, 128'h0);
        chk("fl_occ",      128'(a_occ), 128'd0);
        chk("fl_valid",    128'(a_out_valid), 128'd0);
        chk("fl_ctrl",     128'(a_out_ctrl), 128'd0);
        chk("fl_in_ready", 128'(a_in_ready), 128'd1);
        chk("fl_stall",    128'(a_stall), 128'd4);
        a_out_ready = 1'b1;
        step();
        chk("fl_no_d_valid", 128'(a_out_valid), 128'd0);
        chk("fl_no_d_data",  a_out_data, 128'd0);
        a_out_ready = 1'b0;

        // 4. stall counter saturation (CNT_W=4)
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        a_offer(1'b1, 16'h0047, 128'h4747);
        step();
        a_offer(1'b0, 16'h0, 128'h0);
        chk("sat_start", 128'(a_stall), 128'd0);
        chk("sat_occ",   128'(a_occ), 128'd1);
        repeat (14) step();
        chk("sat_14", 128'(a_stall), 128'd14);
        repeat (6) step();
        chk("sat_hold", 128'(a_stall), 128'd15);
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        chk("sat_flush_keep",  128'(a_stall), 128'd15);
        chk("sat_flush_valid", 128'(a_out_valid), 128'd0);
        step();
        chk("sat_after", 128'(a_stall), 128'd15);

        // 5. SKID=0 combinational ready
        b_in_valid = 1'b1; b_in_ctrl = 16'h0011; b_in_data = 128'h1111;
        b_out_ready = 1'b0;
        step();
        b_in_ctrl = 16'h0022; b_in_data = 128'h2222;
        #1;
        chk("s0_ready_lo", 128'(b_in_ready), 128'd0);
        step();
        chk("s0_hold_head", b_out_data, 128'h1111);
        chk("s0_hold_occ",  128'(b_occ), 128'd1);
        b_out_ready = 1'b1;
        #1;
        chk("s0_ready_hi", 128'(b_in_ready), 128'd1);
        step();
        b_in_valid = 1'b0;
        chk("s0_replace_data", b_out_data, 128'h2222);
        chk("s0_replace_ctrl", 128'(b_out_ctrl), 128'h0022);
        chk("s0_replace_occ",  128'(b_occ), 128'd1);
        chk("s0_stall",        128'(b_stall), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the CPU pipeline. It carries a control bundle and a data bundle between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and adds what a bare flop stage lacks:
- a valid bit per entry;
- a valid/ready stall handshake;
- an optional 2-entry skid buffer, so in_ready is registered;
- flush-to-bubble;
- a saturating stall-cycle counter for performance debug.

Parameters:
CTRL_W, 16, width of control bundle (RegWrite, MemToReg, ALUOp, ...); all-zero means NOP.
DATA_W, 128, width of data bundle (operands, immediate, register addresses).
SKID, 1, 0 = single entry with combinational in_ready; 1 = two entries with registered in_ready.
CNT_W, 16, width of the stall counter.

Ports:
clock  in  1  pipeline clock; all state updates on its rising edge.
reset_n  in  1  synchronous, active-low reset.
flush  in  1  discard all held and incoming entries this cycle.
in_valid  in  1  upstream stage presents an entry.
in_ready  out  1  stage can accept an entry.
in_ctrl  in  CTRL_W  upstream control bundle.
in_data  in  DATA_W  upstream data bundle.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream consumes the head this cycle.
out_ctrl  out  CTRL_W  head control; forced to 0 when out_valid=0.
out_data  out  DATA_W  head data; forced to 0 when out_valid=0.
occupancy  out  2  entries held (0..2; max 1 when SKID=0).
stall_count  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake rules:
  - Accept when in_valid && in_ready.
  - Consume when out_valid && out_ready.
  - in_valid with in_ready=0 means upstream must hold its entry; nothing is captured.
- Reset: when reset_n=0 at a clock edge, the following all go to 0: occupancy, out_valid, out_ctrl, out_data, stall_count, and both entries. in_ready is 1 after reset.
- Latency: an entry accepted in cycle N appears at out_* in cycle N+1. Throughput is 1 entry/clock when out_ready is held at 1.
- SKID=0 (single entry):
  - in_ready = !out_valid || out_ready (combinational).
  - Accept with consume in the same cycle replaces the head.
- SKID=1 states, encoded in occupancy:
  - EMPTY(0): accept -> HEAD.
  - HEAD(1):
    - accept without consume -> FULL, new entry goes to the skid slot;
    - accept with consume -> HEAD, new entry becomes the head;
    - consume only -> EMPTY.
  - FULL(2):
    - in_ready=0;
    - consume -> HEAD, skid slot moves to head;
    - no consume -> stay FULL.
  - in_ready = (occupancy != 2), driven from a register; no combinational path from out_ready.
  - Head order is strictly FIFO; the skid entry never overtakes the head.
- Flush:
  - Takes priority over every other event except reset.
  - Next state is EMPTY: occupancy=0, out_valid=0, out_ctrl/out_data=0.
  - An entry offered in the flush cycle is dropped, even if the handshake completed.
  - A consume in the flush cycle still counts as consumed by downstream.
  - The cycle after a flush, in_ready=1.
- stall_count:
  - Increments by 1 in each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Cleared only by reset; flush does not clear it.
- Simultaneous events:
  - Reset beats flush, and flush beats accept/consume.
  - Accept+consume in FULL is impossible (in_ready=0); in_valid is ignored.
- A mid-operation reset discards all entries with no partial output.

Decomposition:
- Shared package pipe_pkg holds:
  - occupancy encodings OCC_EMPTY=0, OCC_HEAD=1, OCC_FULL=2;
  - NOP_CTRL = all-zero;
  - per-stage CTRL_W/DATA_W constants (ID_EX_CTRL_W, ID_EX_DATA_W, ...).
- One natural sub-module: sat_counter (width-parametrised saturating incrementer with clear), used for stall_count.
- Entry storage and the state machine stay inline.

Test Plan:
1. Reset, streaming, reset hold:
   - reset_n=0 for 2 cycles, then 1 -> all outputs 0, in_ready=1.
   - in_valid=1 with in_ctrl=16'h00A5, in_data=128'h1234, out_ready=1 -> out_valid=1 with those values next cycle, occupancy=1.
   - Stream of 8 entries with out_ready=1 -> 8 entries out in order, 1/clock.
   - Mid-stream reset_n=0 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, stall_count=0.
2. SKID=1 backpressure:
   - Accept A, then B while out_ready=0 -> occupancy=2, in_ready=0 the following cycle, out_data=A.
   - C offered while in_ready=0 is not captured.
   - out_ready=1 for 2 cycles -> A then B, then occupancy=0.
3. Flush with concurrent offer:
   - occupancy=2 with flush=1 and in_valid=1 (entry D) in the same cycle -> next cycle occupancy=0, out_valid=0, out_ctrl=0, in_ready=1.
   - D never appears at the output.
4. stall_count saturation:
   - CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_count reaches 15 and holds.
   - Flush -> stall_count remains 15.
5. SKID=0 combinational ready:
   - Head full, out_ready=0 -> in_ready=0 in the same cycle.
   - out_ready=1 -> in_ready=1 in the same cycle; accept+consume leaves occupancy=1 with the new entry at the head.
